// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath select codes and the one-hot instruction class indices.
package rv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] IMM    = 7'b0010011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'b0000000;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JAL   = 2'b10;
    localparam logic [1:0] PC_JALR  = 2'b11;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    // One-hot class vector bit positions; the upper-immediate classes only
    // exist when that feature is built in.
    localparam int CL_R    = 0;
    localparam int CL_IMM  = 1;
    localparam int CL_LW   = 2;
    localparam int CL_SW   = 3;
    localparam int CL_BR   = 4;
    localparam int CL_JAL  = 5;
    localparam int CL_JALR = 6;
    localparam int CL_HALT = 7;
`ifdef RVCTRL_UPIMM_EN
    localparam int CL_LUI   = 8;
    localparam int CL_AUIPC = 9;
    localparam int NCLASS   = 10;
`else
    localparam int NCLASS   = 8;
`endif

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> one-hot class decode; illegal when no class matches.
// LUI/AUIPC are recognised only when RVCTRL_UPIMM_EN is defined.
module opcode_classifier
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]        opcode,
    output logic [NCLASS-1:0] cls,
    output logic              illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            R_TYPE:  cls[CL_R]    = 1'b1;
            IMM:     cls[CL_IMM]  = 1'b1;
            LW:      cls[CL_LW]   = 1'b1;
            SW:      cls[CL_SW]   = 1'b1;
            BR:      cls[CL_BR]   = 1'b1;
            JAL:     cls[CL_JAL]  = 1'b1;
            JALR:    cls[CL_JALR] = 1'b1;
            HALT:    cls[CL_HALT] = 1'b1;
`ifdef RVCTRL_UPIMM_EN
            LUI:     cls[CL_LUI]   = 1'b1;
            AUIPC:   cls[CL_AUIPC] = 1'b1;
`endif
            default: cls = '0;
        endcase
        illegal = ~|cls;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM over one shared memory port; holds mem_req until mem_ready,
// faults after TIMEOUT unanswered cycles. Optional LUI/AUIPC support via RVCTRL_UPIMM_EN.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       halted,
    output logic       fault,
    output logic [1:0] fault_cause,
    output logic [2:0] state
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [6:0]        opc_q, opc_d;
    logic [1:0]        cause_q, cause_d;
    logic [NCLASS-1:0] cls;
    logic              illegal;
    logic              timed_out;

    // Opcode is captured in DECODE so later states do not depend on ir staying put.
    assign opc_d     = (state_q == ST_DECODE) ? opcode : opc_q;
    assign timed_out = (to_q == TO_LAST) && !mem_ready;

    opcode_classifier u_cls (
        .opcode  (opc_d),
        .cls     (cls),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            to_q    <= '0;
            opc_q   <= '0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            opc_q   <= opc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        mem_req       = 1'b0;
        iord          = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_PLUS4;
        alu_src_a     = SRCA_RS1;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        mem_to_reg    = M2R_ALU;
        reg_write     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                    cause_d = FC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (cls[CL_HALT]) begin
                    state_d = ST_HALTED;
                end else if (illegal) begin
                    state_d = ST_FAULT;
                    cause_d = FC_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (cls[CL_R]) begin
                    alu_op  = ALU_R;
                    state_d = ST_WB;
                end else if (cls[CL_IMM]) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_I;
                    state_d = ST_WB;
                end else if (cls[CL_LW] || cls[CL_SW]) begin
                    alu_src = 1'b1;
                    state_d = ST_MEM;
                end else if (cls[CL_BR]) begin
                    alu_op        = ALU_BR;
                    pc_write_cond = 1'b1;
                    pc_src        = PC_BR;
                end else if (cls[CL_JAL]) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_JAL;
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_PC4;
                end else if (cls[CL_JALR]) begin
                    alu_src    = 1'b1;
                    alu_op     = ALU_I;
                    pc_write   = 1'b1;
                    pc_src     = PC_JALR;
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_PC4;
                end
`ifdef RVCTRL_UPIMM_EN
                else if (cls[CL_LUI] || cls[CL_AUIPC]) begin
                    alu_src   = 1'b1;
                    alu_src_a = cls[CL_LUI] ? SRCA_ZERO : SRCA_PC;
                    state_d   = ST_WB;
                end
`endif
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = cls[CL_SW];
                if (mem_ready) begin
                    state_d = cls[CL_LW] ? ST_WB : ST_FETCH;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                    cause_d = FC_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = cls[CL_LW] ? M2R_MEM : M2R_ALU;
                state_d    = ST_FETCH;
            end
            ST_HALTED, ST_FAULT: state_d = state_q;
            default:             state_d = ST_FETCH;
        endcase
        // Strobes are suppressed while reset is high so an aborted access never fires.
        if (reset) begin
            mem_req       = 1'b0;
            iord          = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            to_d = '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
            to_d = to_q + 1'b1;
        end else begin
            to_d = to_q;
        end
    end

    assign halted      = (state_q == ST_HALTED);
    assign fault       = (state_q == ST_FAULT);
    assign fault_cause = cause_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-class table, hand-written corner
// sequences, and randomized instruction streams against a cycle-list reference model.
module tb_multicycle_controller;
    import rv_ctrl_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, iord, mem_we, ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] pc_src, alu_src_a, alu_op, mem_to_reg, fault_cause;
    logic       alu_src, halted, fault;
    logic [2:0] state;

    multicycle_controller #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src(alu_src), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .halted(halted),
        .fault(fault), .fault_cause(fault_cause), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req, iord, we, irw, pcw, pcwc;
        logic [1:0] pcsrc, asa;
        logic       asrc;
        logic [1:0] aop, m2r;
        logic       rw;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        int         cpi;
        ctl_t       ex;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ctl_t eq[$];
    logic rq[$];

    function automatic ctl_t mk(input logic [2:0] st, input logic req, input logic io,
                                input logic we, input logic irw, input logic pcw,
                                input logic pcwc, input logic [1:0] pcsrc,
                                input logic [1:0] asa, input logic asrc,
                                input logic [1:0] aop, input logic [1:0] m2r, input logic rw);
        ctl_t c;
        c.st = st; c.req = req; c.iord = io; c.we = we; c.irw = irw; c.pcw = pcw;
        c.pcwc = pcwc; c.pcsrc = pcsrc; c.asa = asa; c.asrc = asrc; c.aop = aop;
        c.m2r = m2r; c.rw = rw;
        return c;
    endfunction

    function automatic ctl_t act();
        return mk(state, mem_req, iord, mem_we, ir_write, pc_write, pc_write_cond,
                  pc_src, alu_src_a, alu_src, alu_op, mem_to_reg, reg_write);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Expected EXEC-cycle controls derived from the instruction-class rules.
    function automatic ctl_t exec_exp(input logic [6:0] op);
        ctl_t c = '0;
        c.st = 3'd2;
        case (op)
            R_TYPE: c.aop = 2'b10;
            IMM:    begin c.asrc = 1'b1; c.aop = 2'b11; end
            LW, SW: c.asrc = 1'b1;
            BR:     begin c.aop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
            JAL:    begin c.pcw = 1'b1; c.pcsrc = 2'b10; c.rw = 1'b1; c.m2r = 2'b10; end
            JALR:   begin c.asrc = 1'b1; c.aop = 2'b11; c.pcw = 1'b1; c.pcsrc = 2'b11;
                          c.rw = 1'b1; c.m2r = 2'b10; end
            LUI:    begin c.asrc = 1'b1; c.asa = 2'b10; end
            AUIPC:  begin c.asrc = 1'b1; c.asa = 2'b01; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Reference model: expand one instruction into its expected per-cycle trace
    // plus the mem_ready value to drive in each cycle.
    task automatic build(input logic [6:0] op, input int fw, input int mw);
        ctl_t c;
        for (int i = 0; i <= fw; i++) begin
            c = '0; c.st = 3'd0; c.req = 1'b1;
            c.irw = (i == fw); c.pcw = (i == fw);
            eq.push_back(c); rq.push_back(i == fw);
        end
        c = '0; c.st = 3'd1;
        eq.push_back(c); rq.push_back(1'($urandom));
        eq.push_back(exec_exp(op)); rq.push_back(1'($urandom));
        if (op == LW || op == SW) begin
            for (int i = 0; i <= mw; i++) begin
                c = '0; c.st = 3'd3; c.req = 1'b1; c.iord = 1'b1; c.we = (op == SW);
                eq.push_back(c); rq.push_back(i == mw);
            end
        end
        if (op == R_TYPE || op == IMM || op == LW || op == LUI || op == AUIPC) begin
            c = '0; c.st = 3'd4; c.rw = 1'b1; c.m2r = (op == LW) ? 2'b01 : 2'b00;
            eq.push_back(c); rq.push_back(1'($urandom));
        end
    endtask

    task automatic run_q(input logic [6:0] op, input string tag);
        ctl_t e;
        while (eq.size() > 0) begin
            e = eq.pop_front();
            mem_ready = rq.pop_front();
            opcode = (e.st == 3'd0) ? 7'($urandom) : op;
            @(negedge clk);
            chk(tag, {13'b0, act()}, {13'b0, e});
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tv[7];
        logic [6:0] legal[9];
        int         nleg;
        int         n;
        ctl_t       ex_got;
        logic [6:0] op;

        tv[0] = '{R_TYPE, 4, mk(2, 0,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0)};
        tv[1] = '{IMM,    4, mk(2, 0,0,0,0,0,0, 2'b00, 2'b00, 1, 2'b11, 2'b00, 0)};
        tv[2] = '{LW,     5, mk(2, 0,0,0,0,0,0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0)};
        tv[3] = '{SW,     4, mk(2, 0,0,0,0,0,0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0)};
        tv[4] = '{BR,     3, mk(2, 0,0,0,0,0,1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 0)};
        tv[5] = '{JAL,    3, mk(2, 0,0,0,0,1,0, 2'b10, 2'b00, 0, 2'b00, 2'b10, 1)};
        tv[6] = '{JALR,   3, mk(2, 0,0,0,0,1,0, 2'b11, 2'b00, 1, 2'b11, 2'b10, 1)};

        legal = '{R_TYPE, IMM, LW, SW, BR, JAL, JALR, LUI, AUIPC};
`ifdef RVCTRL_UPIMM_EN
        nleg = 9;
`else
        nleg = 7;
`endif

        // Reset state
        opcode = 7'd0;
        do_reset();
        @(negedge clk);
        chk("rst_ctl", {13'b0, act()}, {13'b0, mk(0, 1,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0)});
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        step();

        // R-type with zero-wait memory, then LW with three MEM wait cycles
        build(R_TYPE, 0, 0);
        run_q(R_TYPE, "rtype_seq");
        build(LW, 0, 3);
        chk("lw_wait_len", 32'(eq.size()), 32'd8);
        run_q(LW, "lw_wait_seq");

        // Per-class table: EXEC controls and cycles per instruction
        for (int k = 0; k < 7; k++) begin
            mem_ready = 1'b1;
            opcode = tv[k].op;
            n = 0;
            ex_got = '0;
            do begin
                @(negedge clk);
                if (n == 2) ex_got = act();
                step();
                n++;
            end while (state != 3'd0 && n < 12);
            chk($sformatf("tbl_cpi_%0d", k), 32'(n), 32'(tv[k].cpi));
            chk($sformatf("tbl_exec_%0d", k), {13'b0, ex_got}, {13'b0, tv[k].ex});
        end

        // FETCH timeout: four unanswered cycles fault, sticky until reset
        do_reset();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            chk("to_wait_state", 32'(state), 32'd0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("to_fault_ctl", {13'b0, act()}, {13'b0, mk(6, 0,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0)});
            chk("to_fault_flag", 32'({fault, halted, fault_cause}), 32'b1010);
            step();
        end
        do_reset();
        @(negedge clk);
        chk("to_cleared", 32'({fault, fault_cause}), 32'd0);
        for (int i = 0; i < TO; i++) begin
            mem_ready = (i == TO - 1);
            step();
        end
        @(negedge clk);
        chk("to_ready_last", 32'(state), 32'd1);

        // MEM timeout on a store
        do_reset();
        opcode = SW;
        mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        for (int i = 0; i < TO; i++) step();
        @(negedge clk);
        chk("mem_to_state", 32'({state, fault_cause}), {27'd0, 3'd6, 2'b10});

        // Illegal opcode
        do_reset();
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        step(); step();
        @(negedge clk);
        chk("illegal", 32'({state, fault, fault_cause}), {26'd0, 3'd6, 1'b1, 2'b01});

        // Upper-immediate opcodes
        for (int u = 0; u < 2; u++) begin
            op = (u == 0) ? LUI : AUIPC;
            do_reset();
            opcode = op;
            mem_ready = 1'b1;
            step(); step();
            @(negedge clk);
`ifdef RVCTRL_UPIMM_EN
            chk("upimm_exec", {13'b0, act()}, {13'b0, exec_exp(op)});
            step();
            @(negedge clk);
            chk("upimm_wb", 32'({state, reg_write, mem_to_reg}), {26'd0, 3'd4, 1'b1, 2'b00});
`else
            chk("upimm_illegal", 32'({state, fault_cause}), {27'd0, 3'd6, 2'b01});
`endif
        end

        // HALT is absorbing with every strobe low
        do_reset();
        opcode = HALT;
        mem_ready = 1'b1;
        step(); step();
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom);
            opcode = 7'($urandom);
            @(negedge clk);
            chk("halt_ctl", {13'b0, act()}, {13'b0, mk(5, 0,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0)});
            chk("halt_flags", 32'({halted, fault}), 32'b10);
            step();
        end

        // Reset during the MEM cycle of a store
        do_reset();
        opcode = SW;
        mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sw_mem_we", 32'({state, mem_we}), {28'd0, 3'd3, 1'b1});
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("sw_rst_abort", 32'({state, mem_we, halted, fault, fault_cause}), {25'd0, 3'd0, 4'b0, 1'b0, 1'b0, 1'b0});
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("sw_rst_fetch", 32'({state, mem_req, iord, mem_we}), {26'd0, 3'd0, 3'b100});
        step();

        // Randomized instruction stream with wait states up to the timeout boundary
        do_reset();
        for (int i = 0; i < 40; i++) begin
            op = legal[$urandom_range(0, nleg - 1)];
            build(op, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
            run_q(op, $sformatf("rand_%0d_op%b", i, op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
